vend_multi_item: RTL and testbench
==================================

# vend_multi_item

Parametrised vending controller for NUM_ITEMS products with per-item prices, credit accumulation across nickel/dime/quarter coins, explicit item selection, cancel/refund, and serial change return in nickels. It supersedes the fixed-price single-item controllers and drives the coin-return solenoid and item-release latch directly.

## Interface

Parameters:
- NUM_ITEMS, 3, number of selectable items (≥1).
- CREDIT_W, 5, credit register width in nickel units.
- MAX_CREDIT, 20, highest credit accepted, in nickels (≤ 2^CREDIT_W − 1).
- PRICES, {5'd6, 5'd5, 5'd4}, packed NUM_ITEMS×CREDIT_W price table in nickels; item i at bits [i*CREDIT_W +: CREDIT_W]. Default prices: item0 = 4, item1 = 5, item2 = 6.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- nickel_in  in  1  single-cycle pulse, 1 nickel.
- dime_in  in  1  single-cycle pulse, 2 nickels.
- quarter_in  in  1  single-cycle pulse, 5 nickels.
- select  in  NUM_ITEMS  item request; one-hot expected.
- cancel  in  1  refund request pulse.
- dispense  out  1  one-cycle item release.
- item_id  out  $clog2(NUM_ITEMS) (min 1)  item released; valid with dispense.
- nickel_out  out  1  one pulse per nickel returned.
- coin_reject  out  1  one-cycle pulse: a presented coin was not credited.
- insufficient  out  1  one-cycle pulse: selection refused for low credit.
- busy  out  1  high in DISPENSE and CHANGE.
- credit  out  CREDIT_W  current credit in nickels.

## Operation

- States: IDLE (accumulate), DISPENSE, CHANGE.
- IDLE coin handling:
  - At most one coin is credited per cycle, with priority quarter > dime > nickel.
  - Any other coin present in the same cycle pulses coin_reject.
  - A coin that would make credit exceed MAX_CREDIT is not credited: credit unchanged, coin_reject pulses.
- IDLE select:
  - Lowest set bit wins.
  - If credit ≥ price: go to DISPENSE and set credit −= price.
  - Otherwise pulse insufficient; credit and state unchanged.
  - Select takes priority over a coin in the same cycle; that coin is rejected.
- IDLE cancel:
  - If credit > 0, go to CHANGE. If credit = 0, ignore.
  - Cancel has lower priority than select.
- DISPENSE lasts one cycle: dispense = 1 and item_id is valid. Next state is CHANGE if credit > 0, else IDLE.
- CHANGE: nickel_out = 1 every cycle and credit decrements by 1 each cycle. The state moves to IDLE in the same cycle credit becomes 0.
- In DISPENSE and CHANGE:
  - Every coin pulses coin_reject.
  - select and cancel are ignored.
- Reset, including mid-operation:
  - State IDLE, credit 0, and all outputs 0.
  - Pending change is discarded.

## Timing

- All outputs are registered.
- A coin sampled at edge n is reflected in credit from cycle n+1. coin_reject is high in cycle n+1.
- A select accepted at edge n gives dispense high in cycle n+1. The first nickel_out is in cycle n+2.
- Change of k nickels gives k consecutive nickel_out cycles. busy stays high from dispense until the cycle after the last nickel.
- Cancel at edge n gives the first nickel_out in cycle n+1.
- insufficient is high in cycle n+1 after the refused select.

## Configuration

- VEND_QUARTER_EN defined: quarter_in is credited as 5 nickels, as above.
- VEND_QUARTER_EN undefined:
  - The quarter_in port remains present.
  - Every quarter_in pulse, in any state, gives coin_reject with no credit.
  - Priority among the remaining coins is dime > nickel.

## Structure

- Shared package vend_pkg holds:
  - the state enum (IDLE, DISPENSE, CHANGE);
  - coin value constants NICKEL_V = 1, DIME_V = 2, QUARTER_V = 5;
  - the default price constants.
- Sub-module vend_coin_accept holds the coin priority, saturation check and reject generation. It outputs add_value and reject; the top holds the FSM and the credit register.

## Test plan

- Defaults. Dime, dime, select = 3'b001 → dispense = 1 with item_id = 0 for one cycle; no nickel_out; credit = 0; busy low after.
- Quarter, then select = 3'b001 → dispense; one nickel_out pulse in the next cycle; credit = 0.
- Three nickels, then select = 3'b100 → insufficient pulse; credit stays 3. Then cancel → three consecutive nickel_out pulses, busy high throughout, credit 3→0.
- Credit 19, then dime → coin_reject; credit stays 19. Then nickel → credit 20. Then nickel → coin_reject.
- Nickel and dime in the same cycle in IDLE → credit +2; coin_reject pulses once. Coin during CHANGE → coin_reject; change count unaffected. Reset during CHANGE → credit 0, no further nickel_out.
- VEND_QUARTER_EN undefined: quarter_in → coin_reject; credit unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-item vending controller:
// FSM state encoding, coin values in nickels and the default price table.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } vend_state_t;

    localparam int unsigned NICKEL_V  = 1;
    localparam int unsigned DIME_V    = 2;
    localparam int unsigned QUARTER_V = 5;

    localparam int unsigned PRICE_ITEM0 = 4;
    localparam int unsigned PRICE_ITEM1 = 5;
    localparam int unsigned PRICE_ITEM2 = 6;

    localparam logic [14:0] DEFAULT_PRICES = {5'(PRICE_ITEM2), 5'(PRICE_ITEM1), 5'(PRICE_ITEM0)};

    // Item index width; a single-item machine still gets a 1-bit id.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_coin_accept.sv
// Coin acceptor: picks at most one coin per cycle, refuses coins that would
// overflow MAX_CREDIT, and flags every coin it does not credit.
// Quarters are credited only when VEND_QUARTER_EN is defined.
module vend_coin_accept
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 5,
    parameter int MAX_CREDIT = 20
) (
    input  logic                accept_en,
    input  logic                nickel_in,
    input  logic                dime_in,
    input  logic                quarter_in,
    input  logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] add_value,
    output logic                reject
);

    localparam int SUM_W = CREDIT_W + 1;

    logic [CREDIT_W-1:0] value;
    logic                others;
    logic                forced_reject;
    logic [SUM_W-1:0]    sum;
    logic                over;

    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        value         = '0;
        others        = 1'b0;
        forced_reject = 1'b0;
`ifdef VEND_QUARTER_EN
        if (quarter_in) begin
            value  = CREDIT_W'(QUARTER_V);
            others = dime_in | nickel_in;
        end else if (dime_in) begin
            value  = CREDIT_W'(DIME_V);
            others = nickel_in;
        end else if (nickel_in) begin
            value  = CREDIT_W'(NICKEL_V);
        end
`else
        forced_reject = quarter_in;
        if (dime_in) begin
            value  = CREDIT_W'(DIME_V);
            others = nickel_in;
        end else if (nickel_in) begin
            value  = CREDIT_W'(NICKEL_V);
        end
`endif
        sum  = {1'b0, credit} + {1'b0, value};
        over = (value != '0) && (sum > SUM_W'(MAX_CREDIT));

        if (accept_en) begin
            add_value = over ? '0 : value;
            reject    = others | forced_reject | over;
        end else begin
            add_value = '0;
            reject    = nickel_in | dime_in | quarter_in;
        end
    end

endmodule

// File: rtl/vend_multi_item.sv
// Multi-item vending controller: credit register, IDLE/DISPENSE/CHANGE FSM
// with registered outputs. Quarter crediting is gated by VEND_QUARTER_EN.
module vend_multi_item
    import vend_pkg::*;
#(
    parameter int                              NUM_ITEMS  = 3,
    parameter int                              CREDIT_W   = 5,
    parameter int                              MAX_CREDIT = 20,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICES     = DEFAULT_PRICES
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              nickel_in,
    input  logic                              dime_in,
    input  logic                              quarter_in,
    input  logic [NUM_ITEMS-1:0]              select,
    input  logic                              cancel,
    output logic                              dispense,
    output logic [id_width(NUM_ITEMS)-1:0]    item_id,
    output logic                              nickel_out,
    output logic                              coin_reject,
    output logic                              insufficient,
    output logic                              busy,
    output logic [CREDIT_W-1:0]               credit
);

    localparam int ID_W = id_width(NUM_ITEMS);

    vend_state_t         state;
    logic                sel_valid;
    logic [ID_W-1:0]     sel_idx;
    logic [CREDIT_W-1:0] sel_price;
    logic                accept_en;
    logic [CREDIT_W-1:0] add_value;
    logic                reject_c;

    // Lowest set select bit wins: scanning downward lets the lowest overwrite.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_price = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (select[i]) begin
                sel_valid = 1'b1;
                sel_idx   = ID_W'(i);
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // A selection in IDLE claims the cycle, so any coin alongside it is refused.
    assign accept_en = (state == IDLE) && !sel_valid;

    vend_coin_accept #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_coin_accept (
        .accept_en  (accept_en),
        .nickel_in  (nickel_in),
        .dime_in    (dime_in),
        .quarter_in (quarter_in),
        .credit     (credit),
        .add_value  (add_value),
        .reject     (reject_c)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= '0;
            dispense     <= 1'b0;
            item_id      <= '0;
            nickel_out   <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dispense     <= 1'b0;
            item_id      <= '0;
            nickel_out   <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= reject_c;

            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        if (credit >= sel_price) begin
                            state    <= DISPENSE;
                            credit   <= credit - sel_price;
                            dispense <= 1'b1;
                            item_id  <= sel_idx;
                            busy     <= 1'b1;
                        end else begin
                            insufficient <= 1'b1;
                        end
                    end else begin
                        credit <= credit + add_value;
                        if (cancel && credit != '0) begin
                            state      <= CHANGE;
                            nickel_out <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end

                DISPENSE: begin
                    if (credit != '0) begin
                        state      <= CHANGE;
                        nickel_out <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                CHANGE: begin
                    // Each CHANGE cycle pays one nickel; leave when the last one is paid.
                    if (credit <= CREDIT_W'(1)) begin
                        credit <= '0;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        credit     <= credit - CREDIT_W'(1);
                        nickel_out <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    credit <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_multi_item.sv
// Self-checking bench for vend_multi_item: directed scenarios plus a randomized
// run against a transaction-level reference model (schedule of busy cycles).
module tb_vend_multi_item;

    localparam int NUM_ITEMS  = 3;
    localparam int CREDIT_W   = 5;
    localparam int MAX_CREDIT = 20;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                nickel_in = 1'b0;
    logic                dime_in = 1'b0;
    logic                quarter_in = 1'b0;
    logic [2:0]          select = 3'b000;
    logic                cancel = 1'b0;
    logic                dispense;
    logic [1:0]          item_id;
    logic                nickel_out;
    logic                coin_reject;
    logic                insufficient;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    vend_multi_item dut (
        .clock        (clock),
        .reset        (reset),
        .nickel_in    (nickel_in),
        .dime_in      (dime_in),
        .quarter_in   (quarter_in),
        .select       (select),
        .cancel       (cancel),
        .dispense     (dispense),
        .item_id      (item_id),
        .nickel_out   (nickel_out),
        .coin_reject  (coin_reject),
        .insufficient (insufficient),
        .busy         (busy),
        .credit       (credit)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: idle credit plus a queue of the machine's upcoming busy cycles.
    typedef struct {
        bit disp;
        int id;
        int credit;
    } rec_t;

    int   price [3] = '{4, 5, 6};
    int   m_credit = 0;
    bit   m_busy = 0;
    rec_t q[$];

    bit e_disp, e_nick, e_rej, e_ins, e_busy;
    int e_id, e_credit;

    task automatic step(input bit n, input bit d, input bit qt, input logic [2:0] sel,
                        input bit can, input bit rst);
        int   sel_i;
        int   val;
        bit   others;
        int   old_credit;
        rec_t r;
        nickel_in  = n;
        dime_in    = d;
        quarter_in = qt;
        select     = sel;
        cancel     = can;
        reset      = rst;

        e_rej = 0; e_ins = 0;
        if (rst) begin
            q.delete();
            m_credit = 0;
        end else if (m_busy) begin
            e_rej = n | d | qt;
        end else begin
            sel_i = -1;
            for (int i = 2; i >= 0; i--) if (sel[i]) sel_i = i;
            old_credit = m_credit;
            if (sel_i >= 0) begin
                e_rej = n | d | qt;
                if (m_credit >= price[sel_i]) begin
                    m_credit -= price[sel_i];
                    q.push_back('{disp: 1'b1, id: sel_i, credit: m_credit});
                    for (int k = m_credit; k >= 1; k--) q.push_back('{disp: 1'b0, id: 0, credit: k});
                    m_credit = 0;
                end else begin
                    e_ins = 1;
                end
            end else begin
                val = 0; others = 0;
`ifdef VEND_QUARTER_EN
                if (qt) begin val = 5; others = d | n; end
                else if (d) begin val = 2; others = n; end
                else if (n) val = 1;
`else
                if (qt) e_rej = 1;
                if (d) begin val = 2; others = n; end
                else if (n) val = 1;
`endif
                if (val > 0) begin
                    if (m_credit + val > MAX_CREDIT) e_rej = 1;
                    else m_credit += val;
                end
                if (others) e_rej = 1;
                if (can && old_credit > 0) begin
                    for (int k = m_credit; k >= 1; k--) q.push_back('{disp: 1'b0, id: 0, credit: k});
                    m_credit = 0;
                end
            end
        end

        if (rst) e_rej = 0;
        if (q.size() > 0) begin
            r = q.pop_front();
            m_busy = 1; e_busy = 1;
            e_disp = r.disp; e_nick = !r.disp; e_id = r.id; e_credit = r.credit;
        end else begin
            m_busy = 0; e_busy = 0;
            e_disp = 0; e_nick = 0; e_id = 0; e_credit = m_credit;
        end

        @(posedge clock);
        #1;
        nickel_in = 0; dime_in = 0; quarter_in = 0; select = 3'b000; cancel = 0; reset = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 3'b000, 0, 0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin idle(); n++; end
        checks++;
        if (busy !== 1'b0 || credit !== '0) begin
            errors++;
            $display("FAIL %s_drain busy=%b credit=%0d, required busy=0 credit=0", name, busy, credit);
        end
    endtask

    task automatic test_reset();
        step(1, 1, 1, 3'b111, 1, 1);
        step(0, 0, 0, 3'b000, 0, 1);
        checks++;
        if ({dispense, nickel_out, coin_reject, insufficient, busy, credit} !== '0) begin
            errors++;
            $display("FAIL reset_outputs disp=%b nick=%b rej=%b ins=%b busy=%b credit=%0d, required all 0",
                     dispense, nickel_out, coin_reject, insufficient, busy, credit);
        end
    endtask

    task automatic test_exact_dispense();
        step(0, 1, 0, 3'b000, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0);
        checks++;
        if (credit !== 5'd4) begin errors++; $display("FAIL exact_credit got %0d, required 4", credit); end
        step(0, 0, 0, 3'b001, 0, 0);
        checks++;
        if (dispense !== 1'b1 || item_id !== 2'd0 || credit !== 5'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exact_dispense disp=%b id=%0d credit=%0d busy=%b, required 1 0 0 1",
                     dispense, item_id, credit, busy);
        end
        idle();
        checks++;
        if (dispense !== 1'b0 || nickel_out !== 1'b0 || busy !== 1'b0 || credit !== 5'd0) begin
            errors++;
            $display("FAIL exact_after disp=%b nick=%b busy=%b credit=%0d, required 0 0 0 0",
                     dispense, nickel_out, busy, credit);
        end
    endtask

    task automatic test_dispense_change();
`ifdef VEND_QUARTER_EN
        step(0, 0, 1, 3'b000, 0, 0);
`else
        step(0, 1, 0, 3'b000, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0);
        step(1, 0, 0, 3'b000, 0, 0);
`endif
        step(0, 0, 0, 3'b001, 0, 0);
        checks++;
        if (dispense !== 1'b1 || credit !== 5'd1 || nickel_out !== 1'b0) begin
            errors++;
            $display("FAIL change_dispense disp=%b credit=%0d nick=%b, required 1 1 0", dispense, credit, nickel_out);
        end
        idle();
        checks++;
        if (nickel_out !== 1'b1 || busy !== 1'b1 || dispense !== 1'b0) begin
            errors++;
            $display("FAIL change_pulse nick=%b busy=%b disp=%b, required 1 1 0", nickel_out, busy, dispense);
        end
        idle();
        checks++;
        if (nickel_out !== 1'b0 || credit !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL change_end nick=%b credit=%0d busy=%b, required 0 0 0", nickel_out, credit, busy);
        end
    endtask

    task automatic test_insufficient_cancel();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 3'b000, 0, 0);
        step(0, 0, 0, 3'b100, 0, 0);
        checks++;
        if (insufficient !== 1'b1 || credit !== 5'd3 || dispense !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL insufficient ins=%b credit=%0d disp=%b busy=%b, required 1 3 0 0",
                     insufficient, credit, dispense, busy);
        end
        step(0, 0, 0, 3'b000, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (nickel_out !== (i < 3) || busy !== (i < 3) || credit !== 5'(3 - i) || insufficient !== 1'b0) begin
                errors++;
                $display("FAIL cancel_cycle%0d nick=%b busy=%b credit=%0d ins=%b, required %0d %0d %0d 0",
                         i, nickel_out, busy, credit, insufficient, i < 3, i < 3, 3 - i);
            end
            idle();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) step(0, 1, 0, 3'b000, 0, 0);
        step(1, 0, 0, 3'b000, 0, 0);
        checks++;
        if (credit !== 5'd19) begin errors++; $display("FAIL sat_19 got %0d, required 19", credit); end
        step(0, 1, 0, 3'b000, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 5'd19) begin
            errors++;
            $display("FAIL sat_dime rej=%b credit=%0d, required 1 19", coin_reject, credit);
        end
        step(1, 0, 0, 3'b000, 0, 0);
        checks++;
        if (coin_reject !== 1'b0 || credit !== 5'd20) begin
            errors++;
            $display("FAIL sat_nickel20 rej=%b credit=%0d, required 0 20", coin_reject, credit);
        end
        step(1, 0, 0, 3'b000, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 5'd20) begin
            errors++;
            $display("FAIL sat_nickel21 rej=%b credit=%0d, required 1 20", coin_reject, credit);
        end
        step(0, 0, 0, 3'b000, 1, 0);
        drain("sat");
`ifndef VEND_QUARTER_EN
        step(0, 0, 1, 3'b000, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 5'd0) begin
            errors++;
            $display("FAIL quarter_disabled rej=%b credit=%0d, required 1 0", coin_reject, credit);
        end
`endif
    endtask

    task automatic test_coin_mix_and_change();
        int pulses;
        step(1, 1, 0, 3'b000, 0, 0);
        checks++;
        if (credit !== 5'd2 || coin_reject !== 1'b1) begin
            errors++;
            $display("FAIL mix_credit credit=%0d rej=%b, required 2 1", credit, coin_reject);
        end
        idle();
        checks++;
        if (coin_reject !== 1'b0) begin errors++; $display("FAIL mix_single_pulse rej=%b, required 0", coin_reject); end
        step(0, 1, 0, 3'b000, 0, 0);
        step(0, 0, 0, 3'b000, 1, 0);
        pulses = int'(nickel_out);
        for (int i = 0; i < 8; i++) begin
            step(0, i == 1, 0, 3'b000, 0, 0);
            if (i == 1) begin
                checks++;
                if (coin_reject !== 1'b1 || nickel_out !== 1'b1) begin
                    errors++;
                    $display("FAIL change_coin rej=%b nick=%b, required 1 1", coin_reject, nickel_out);
                end
            end
            pulses += int'(nickel_out);
        end
        checks++;
        if (pulses != 4 || credit !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL change_count pulses=%0d credit=%0d busy=%b, required 4 0 0", pulses, credit, busy);
        end
    endtask

    task automatic test_select_priority();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 3'b000, 0, 0);
        step(1, 0, 0, 3'b110, 1, 0);
        checks++;
        if (dispense !== 1'b1 || item_id !== 2'd1 || coin_reject !== 1'b1 || credit !== 5'd1) begin
            errors++;
            $display("FAIL sel_priority disp=%b id=%0d rej=%b credit=%0d, required 1 1 1 1",
                     dispense, item_id, coin_reject, credit);
        end
        drain("sel");
    endtask

    task automatic test_reset_mid_change();
        step(0, 1, 0, 3'b000, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0);
        step(0, 0, 0, 3'b000, 1, 0);
        step(0, 0, 0, 3'b000, 0, 1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nickel_out !== 1'b0 || credit !== 5'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid%0d nick=%b credit=%0d busy=%b, required 0 0 0", i, nickel_out, credit, busy);
            end
            idle();
        end
    endtask

    task automatic test_random();
        bit n, d, qt, can, rst;
        logic [2:0] sel;
        for (int it = 0; it < 600; it++) begin
            n  = ($urandom_range(0, 99) < 30);
            d  = ($urandom_range(0, 99) < 30);
            qt = ($urandom_range(0, 99) < 15);
            sel = ($urandom_range(0, 99) < 15) ? 3'($urandom_range(1, 7)) : 3'b000;
            can = ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 99) < 1);
            if (can) begin n = 0; d = 0; qt = 0; end
            step(n, d, qt, sel, can, rst);
            checks++;
            if (credit !== 5'(e_credit) || busy !== e_busy || dispense !== e_disp || nickel_out !== e_nick ||
                coin_reject !== e_rej || insufficient !== e_ins || (e_disp && item_id !== 2'(e_id))) begin
                errors++;
                $display("FAIL rand_%0d credit=%0d busy=%b disp=%b id=%0d nick=%b rej=%b ins=%b, required %0d %b %b %0d %b %b %b",
                         it, credit, busy, dispense, item_id, nickel_out, coin_reject, insufficient,
                         e_credit, e_busy, e_disp, e_id, e_nick, e_rej, e_ins);
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_exact_dispense();
        test_dispense_change();
        test_insufficient_cancel();
        test_saturation();
        test_coin_mix_and_change();
        test_select_priority();
        test_reset_mid_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
